cic_decimator: RTL and testbench

CIC_DECIMATOR -- requirements
Module: cic_decimator

---
 rtl/cic_decimator_pkg.sv | 19 +
 rtl/cic_comb_stage.sv | 33 +++
 rtl/cic_decimator.sv | 130 +++++++++++++
 tb/tb_cic_decimator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cic_decimator_pkg.sv
// CIC decimator shared defaults and width helpers.
// Also consumed by the half-band filter parameter set.
package cic_decimator_pkg;

  localparam int CIC_ORDER_DEF  = 4;
  localparam int DECIM_DEF      = 64;
  localparam int DIFF_DELAY_DEF = 1;
  localparam int OUT_WIDTH_DEF  = 24;

  // Register growth of an N-stage CIC plus 2 bits for the +/-1 input.
  function automatic int cic_acc_w(
    input int n,
    input int r,
    input int m
  );
    return 2 + n * $clog2(r * m);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One registered CIC comb stage: y = x - x[n-M].
// Delay line advances only on qualified samples.
module cic_comb_stage #(
  parameter int WIDTH = 26,
  parameter int M     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  output logic             out_valid,
  output logic [WIDTH-1:0] y
);

  logic [WIDTH-1:0] dly [M];

  // Difference against the M-deep history, valid follows one clk later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < M; i++) dly[i] <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y      <= x - dly[M-1];
        dly[0] <= x;
        for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// 1-bit sigma-delta CIC decimator: N integrators at input
// rate, decimate by R, N pipelined combs, round and saturate.
module cic_decimator
  import cic_decimator_pkg::*;
#(
  parameter int CIC_ORDER  = CIC_ORDER_DEF,
  parameter int DECIM      = DECIM_DEF,
  parameter int DIFF_DELAY = DIFF_DELAY_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 data_in,
  input  logic                 in_valid,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 out_valid
);

  localparam int ACC_W = cic_acc_w(CIC_ORDER, DECIM, DIFF_DELAY);
  localparam int CNT_W = $clog2(DECIM);
  localparam int SHIFT = ACC_W - OUT_WIDTH - 2;
  localparam int EW    = ACC_W + OUT_WIDTH + 2;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DECIM - 1);

  localparam logic signed [EW-1:0] ONE = EW'(1);
  localparam logic signed [EW-1:0] HI  = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [EW-1:0] LO  = -HI - ONE;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] integ     [CIC_ORDER];
  logic [ACC_W-1:0] integ_nxt [CIC_ORDER];

  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] smp;
  logic             smp_v;

  logic [ACC_W-1:0] cx [CIC_ORDER+1];
  logic [CIC_ORDER:0] cv;

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] rnd;
  logic signed [EW-1:0] sat;

  assign x_ext = data_in ? ACC_W'(1) : '1;

  // Cascaded integrator sums, so the latched sample sees this input.
  always_comb begin
    acc = x_ext;
    for (int i = 0; i < CIC_ORDER; i++) begin
      acc          = integ[i] + acc;
      integ_nxt[i] = acc;
    end
  end

  // Integrator state, wrapping modulo 2^ACC_W on purpose.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CIC_ORDER; i++) integ[i] <= '0;
    end else if (in_valid) begin
      for (int i = 0; i < CIC_ORDER; i++) integ[i] <= integ_nxt[i];
    end
  end

  // Decimation counter and sample latch into the comb pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      smp   <= '0;
      smp_v <= 1'b0;
    end else begin
      smp_v <= 1'b0;
      if (in_valid) begin
        if (cnt == CNT_MAX) begin
          cnt   <= '0;
          smp   <= integ_nxt[CIC_ORDER-1];
          smp_v <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign cx[0] = smp;
  assign cv[0] = smp_v;

  for (genvar g = 0; g < CIC_ORDER; g++) begin : g_comb
    cic_comb_stage #(
      .WIDTH (ACC_W),
      .M     (DIFF_DELAY)
    ) u_comb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (cv[g]),
      .x         (cx[g]),
      .out_valid (cv[g+1]),
      .y         (cx[g+1])
    );
  end

  assign ext = EW'(signed'(cx[CIC_ORDER]));

  if (SHIFT > 0) begin : g_rnd
    localparam logic signed [EW-1:0] HALF = ONE <<< (SHIFT - 1);
    assign rnd = (ext + HALF) >>> SHIFT;
  end else begin : g_nornd
    assign rnd = ext;
  end

  // Clamp to the signed output range.
  always_comb begin
    sat = rnd;
    if (rnd > HI) sat = HI;
    else if (rnd < LO) sat = LO;
  end

  // Output register; data holds between valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= cv[CIC_ORDER];
      if (cv[CIC_ORDER]) data_out <= sat[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator at defaults plus a
// 28-bit-output build that exercises integrator wrap.
module tb_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_in = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] data_out;
  logic        out_valid;
  logic [27:0] data_out28;
  logic        out_valid28;

  always #5 clk = ~clk;

  cic_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .data_out  (data_out),
    .out_valid (out_valid)
  );

  cic_decimator #(.OUT_WIDTH(28)) dut28 (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .data_out  (data_out28),
    .out_valid (out_valid28)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc = 0;
  int b2b   = 0;
  logic prev_ov = 1'b0;

  logic [23:0] ov   [$];
  logic [27:0] ov28 [$];
  int          oc   [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      ov.push_back(data_out);
      ov28.push_back(data_out28);
      oc.push_back(cyc);
    end
    if (out_valid && prev_ov) b2b++;
    prev_ov = out_valid;
  end

  typedef struct {
    int          pat;
    int          period;
    logic [23:0] exp;
    logic [27:0] exp28;
    int          gap;
    string       nm;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic pbit(input int pat, input int k);
    if (pat == 0) return 1'b0;
    if (pat == 1) return 1'b1;
    return (k % 2) == 0;
  endfunction

  task automatic clear_log();
    ov.delete();
    ov28.delete();
    oc.delete();
    b2b = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_log();
    rst_n = 1'b1;
  endtask

  task automatic feed(input int pat, input int period, input int n);
    int k;
    int ph;
    k = 0;
    ph = 0;
    while (k < n) begin
      @(posedge clk); #1;
      if (ph == 0) begin
        in_valid = 1'b1;
        data_in  = pbit(pat, k);
        last_acc = cyc + 1;
        k++;
      end else begin
        in_valid = 1'b0;
      end
      ph = (ph + 1) % period;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    int acc64;
    logic [63:0] a;

    vecs[0] = '{1, 1, 24'h7FFFFF, 28'h1000000, 64,  "ones"};
    vecs[1] = '{0, 1, 24'h800000, 28'hF000000, 64,  "zeros"};
    vecs[2] = '{2, 1, 24'h000000, 28'h0000000, 64,  "alt"};
    vecs[3] = '{2, 3, 24'h000000, 28'h0000000, 192, "alt3"};

    repeat (3) @(negedge clk);
    check("rst_dout", 64'(data_out), 0);
    check("rst_ov", 64'(out_valid), 0);
    check("rst_dout28", 64'(data_out28), 0);

    for (int v = 0; v < 4; v++) begin
      do_reset();
      feed(vecs[v].pat, vecs[v].period, 8 * 64);
      repeat (10) @(posedge clk);
      #1;
      check({vecs[v].nm, "_count"}, 64'(ov.size()), 8);
      for (int j = 4; j < 8; j++) begin
        a = (j < ov.size()) ? 64'(ov[j]) : 'x;
        check($sformatf("%s_out%0d", vecs[v].nm, j + 1), a,
              64'(vecs[v].exp));
        a = (j < ov28.size()) ? 64'(ov28[j]) : 'x;
        check($sformatf("%s_w28_out%0d", vecs[v].nm, j + 1), a,
              64'(vecs[v].exp28));
      end
      a = (oc.size() > 5) ? 64'(oc[5] - oc[4]) : 'x;
      check({vecs[v].nm, "_gap"}, a, 64'(vecs[v].gap));
      check({vecs[v].nm, "_pulse1"}, 64'(b2b), 0);
      check({vecs[v].nm, "_hold"}, 64'(data_out), 64'(vecs[v].exp));
    end

    do_reset();
    feed(1, 1, 100);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("midrst_dout%0d", j), 64'(data_out), 0);
      check($sformatf("midrst_ov%0d", j), 64'(out_valid), 0);
    end
    @(posedge clk); #1;
    clear_log();
    rst_n = 1'b1;
    feed(1, 1, 64);
    acc64 = last_acc;
    repeat (10) @(posedge clk);
    #1;
    check("postrst_count", 64'(oc.size()), 1);
    a = (oc.size() > 0) ? 64'(oc[0] - acc64) : 'x;
    check("postrst_latency", a, 5);

    do_reset();
    feed(0, 1, 64);
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_log();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("inflight_drop", 64'(oc.size()), 0);
    check("inflight_dout", 64'(data_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
